nios_system_gled_pwm: RTL and testbench



---
 rtl/nios_system_gled_pkg.sv | 28 ++
 rtl/nios_system_gled_pwm_timebase.sv | 79 +++++++
 rtl/nios_system_gled_pwm.sv | 121 ++++++++++++
 tb/tb_nios_system_gled_pwm.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_system_gled_pkg.sv
// Shared register map, mode encodings and CTRL layout for the green-LED PWM block.
package nios_system_gled_pkg;

    localparam int unsigned DUTY_W = 8;
    localparam int unsigned CTRL_W = 3;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_DUTY     = 2'd1;
    localparam logic [1:0] ADDR_PRESCALE = 2'd2;
    localparam logic [1:0] ADDR_BLINK    = 2'd3;

    localparam int unsigned CTRL_MODE_LSB = 0;
    localparam int unsigned CTRL_MODE_MSB = 1;
    localparam int unsigned CTRL_INV_BIT  = 2;

    typedef enum logic [1:0] {
        MODE_PASS     = 2'd0,
        MODE_PWM      = 2'd1,
        MODE_BLINK    = 2'd2,
        MODE_PWMBLINK = 2'd3
    } mode_e;

    typedef struct packed {
        logic  invert;
        mode_e mode;
    } ctrl_t;

endpackage

// File: rtl/nios_system_gled_pwm_timebase.sv
// Free-running prescaler, PWM period counter and blink phase generator.
module nios_system_gled_pwm_timebase
    import nios_system_gled_pkg::*;
#(
    parameter int unsigned PRESC_W = 16,
    parameter int unsigned BLINK_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [PRESC_W-1:0] prescale,
    input  logic [DUTY_W-1:0]  duty,
    input  logic [BLINK_W-1:0] blink_half,
    input  logic               presc_clr,
    input  logic               blink_clr,
    output logic               pwm_on_c,
    output logic               blink_phase
);

    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [DUTY_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic               tick;
    logic               period_end;

    // Next-state for all counters; ticks use the register values of this cycle.
    always_comb begin
        tick          = (presc_cnt_q == prescale);
        period_end    = tick && (pwm_cnt_q == '1);
        presc_cnt_d   = presc_cnt_q + PRESC_W'(1);
        pwm_cnt_d     = pwm_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;

        if (presc_clr || tick) begin
            presc_cnt_d = '0;
        end
        if (tick) begin
            pwm_cnt_d = pwm_cnt_q + DUTY_W'(1);
        end

        if (blink_half == '0) begin
            blink_phase_d = 1'b1;
            blink_cnt_d   = '0;
        end else begin
            if (period_end) begin
                if (blink_cnt_q == blink_half - BLINK_W'(1)) begin
                    blink_phase_d = ~blink_phase_q;
                    blink_cnt_d   = '0;
                end else begin
                    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                end
            end
            // A software write restarts the half-period count but keeps the phase.
            if (blink_clr) begin
                blink_cnt_d = '0;
            end
        end
    end

    // Counter state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_cnt_q   <= '0;
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            presc_cnt_q   <= presc_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign pwm_on_c    = (pwm_cnt_q < duty) || (duty == '1);
    assign blink_phase = blink_phase_q;

endmodule

// File: rtl/nios_system_gled_pwm.sv
// Green-LED driver: Avalon-MM control registers, PWM/blink gating, registered pins.
module nios_system_gled_pwm
    import nios_system_gled_pkg::*;
#(
    parameter int unsigned LED_W   = 8,
    parameter int unsigned PRESC_W = 16,
    parameter int unsigned BLINK_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [LED_W-1:0] led_value,
    output logic [LED_W-1:0] led_pins
);

    ctrl_t              ctrl_q, ctrl_d;
    logic [DUTY_W-1:0]  duty_q, duty_d;
    logic [PRESC_W-1:0] prescale_q, prescale_d;
    logic [BLINK_W-1:0] blink_half_q, blink_half_d;
    logic [LED_W-1:0]   led_pins_q, led_pins_d;
    logic               wr_en;
    logic               presc_clr;
    logic               blink_clr;
    logic               pwm_on_c;
    logic               blink_phase;
    logic               gate;
    logic               wdata_unused;

    assign wdata_unused = ^writedata;

    // Register write decode; counter clears are raised alongside the matching write.
    always_comb begin
        wr_en        = chipselect && !write_n;
        ctrl_d       = ctrl_q;
        duty_d       = duty_q;
        prescale_d   = prescale_q;
        blink_half_d = blink_half_q;
        presc_clr    = 1'b0;
        blink_clr    = 1'b0;
        if (wr_en) begin
            case (address)
                ADDR_CTRL: begin
                    ctrl_d.mode   = mode_e'(writedata[CTRL_MODE_MSB:CTRL_MODE_LSB]);
                    ctrl_d.invert = writedata[CTRL_INV_BIT];
                end
                ADDR_DUTY: duty_d = writedata[DUTY_W-1:0];
                ADDR_PRESCALE: begin
                    prescale_d = writedata[PRESC_W-1:0];
                    presc_clr  = 1'b1;
                end
                default: begin
                    blink_half_d = writedata[BLINK_W-1:0];
                    blink_clr    = 1'b1;
                end
            endcase
        end
    end

    // Zero-wait-state read mux, zero-extended.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:     readdata = 32'({ctrl_q.invert, ctrl_q.mode});
            ADDR_DUTY:     readdata = 32'(duty_q);
            ADDR_PRESCALE: readdata = 32'(prescale_q);
            default:       readdata = 32'(blink_half_q);
        endcase
    end

    // Per-mode gate and the next pin value.
    always_comb begin
        gate = 1'b1;
        case (ctrl_q.mode)
            MODE_PASS:     gate = 1'b1;
            MODE_PWM:      gate = pwm_on_c;
            MODE_BLINK:    gate = blink_phase;
            MODE_PWMBLINK: gate = pwm_on_c && blink_phase;
            default:       gate = 1'b1;
        endcase
        led_pins_d = (led_value & {LED_W{gate}}) ^ {LED_W{ctrl_q.invert}};
    end

    // Control registers and output pins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_q       <= '0;
            duty_q       <= '0;
            prescale_q   <= '0;
            blink_half_q <= '0;
            led_pins_q   <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            duty_q       <= duty_d;
            prescale_q   <= prescale_d;
            blink_half_q <= blink_half_d;
            led_pins_q   <= led_pins_d;
        end
    end

    assign led_pins = led_pins_q;

    nios_system_gled_pwm_timebase #(
        .PRESC_W (PRESC_W),
        .BLINK_W (BLINK_W)
    ) u_timebase (
        .clk         (clk),
        .reset_n     (reset_n),
        .prescale    (prescale_q),
        .duty        (duty_q),
        .blink_half  (blink_half_q),
        .presc_clr   (presc_clr),
        .blink_clr   (blink_clr),
        .pwm_on_c    (pwm_on_c),
        .blink_phase (blink_phase)
    );

endmodule

// File: tb/tb_nios_system_gled_pwm.sv
// Self-checking bench for nios_system_gled_pwm: register vectors plus timing sequences.
module tb_nios_system_gled_pwm;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  led_value = 8'h00;
    logic [7:0]  led_pins;

    int total = 0;
    int bad = 0;

    nios_system_gled_pwm dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .led_value  (led_value),
        .led_pins   (led_pins)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  addr;
        logic        cs;
        logic        wn;
        logic [31:0] wdata;
        logic [7:0]  led;
        logic [7:0]  exp_led;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Steps until led_pins leaves from_v; n is the number of edges taken.
    task automatic wait_change(input logic [7:0] from_v, input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (led_pins == from_v && n < bound);
        if (led_pins == from_v) begin
            total++;
            bad++;
            $display("FAIL timeout waiting for change from %h", from_v);
        end
    endtask

    initial begin
        int n;
        int c_ff;
        int c_00;
        int c_other;
        int ntr;
        int tr [8];
        logic [7:0] prev;

        //            addr  cs    wn    wdata          led    exp_led exp_rd
        vecs[0]  = '{2'd0, 1'b1, 1'b0, 32'h0000_0004, 8'h0F, 8'h0F, 32'h4};
        vecs[1]  = '{2'd0, 1'b0, 1'b1, 32'h0000_0000, 8'h0F, 8'hF0, 32'h4};
        vecs[2]  = '{2'd0, 1'b1, 1'b0, 32'hFFFF_FFF8, 8'h0F, 8'hF0, 32'h0};
        vecs[3]  = '{2'd0, 1'b0, 1'b1, 32'h0000_0000, 8'h3C, 8'h3C, 32'h0};
        vecs[4]  = '{2'd1, 1'b1, 1'b0, 32'h1234_5600, 8'h3C, 8'h3C, 32'h0};
        vecs[5]  = '{2'd0, 1'b1, 1'b0, 32'h0000_0001, 8'h3C, 8'h3C, 32'h1};
        vecs[6]  = '{2'd1, 1'b0, 1'b1, 32'h0000_0000, 8'h3C, 8'h00, 32'h0};
        vecs[7]  = '{2'd1, 1'b1, 1'b0, 32'h0000_00FF, 8'h3C, 8'h00, 32'hFF};
        vecs[8]  = '{2'd1, 1'b0, 1'b1, 32'h0000_0000, 8'hC3, 8'hC3, 32'hFF};
        vecs[9]  = '{2'd0, 1'b1, 1'b0, 32'h0000_0005, 8'hC3, 8'hC3, 32'h5};
        vecs[10] = '{2'd0, 1'b0, 1'b1, 32'h0000_0000, 8'h81, 8'h7E, 32'h5};
        vecs[11] = '{2'd2, 1'b1, 1'b0, 32'hABCD_1234, 8'h81, 8'h7E, 32'h1234};
        vecs[12] = '{2'd3, 1'b0, 1'b0, 32'h0000_0055, 8'h81, 8'h7E, 32'h0};
        vecs[13] = '{2'd3, 1'b1, 1'b1, 32'h0000_0066, 8'h81, 8'h7E, 32'h0};
        vecs[14] = '{2'd3, 1'b1, 1'b0, 32'h0001_0007, 8'h81, 8'h7E, 32'h7};
        vecs[15] = '{2'd0, 1'b1, 1'b0, 32'h0000_0000, 8'h81, 8'h7E, 32'h0};
        vecs[16] = '{2'd0, 1'b0, 1'b1, 32'h0000_0000, 8'h81, 8'h81, 32'h0};

        // Reset state and pass-through after release.
        led_value = 8'hA5;
        step(); step(); step();
        chk("reset_pins", 32'(led_pins), 32'h00);
        reset_n = 1'b1;
        step();
        chk("pass_after_reset", 32'(led_pins), 32'hA5);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            chk($sformatf("reset_rd%0d", a), readdata, 32'h0);
        end

        // Register vectors: pins reflect the registers held before each edge.
        for (int i = 0; i < 17; i++) begin
            address    = vecs[i].addr;
            chipselect = vecs[i].cs;
            write_n    = vecs[i].wn;
            writedata  = vecs[i].wdata;
            led_value  = vecs[i].led;
            step();
            chk($sformatf("vec%0d_pins", i), 32'(led_pins), 32'(vecs[i].exp_led));
            chk($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

        // PWM duty with a tick every clock.
        led_value = 8'hFF;
        wr(2'd2, 32'd0);
        wr(2'd1, 32'd64);
        wr(2'd0, 32'd1);
        step(); step(); step();
        c_ff = 0; c_00 = 0; c_other = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (led_pins == 8'hFF) c_ff++;
            else if (led_pins == 8'h00) c_00++;
            else c_other++;
        end
        chk("duty64_on", 32'(c_ff), 32'd64);
        chk("duty64_off", 32'(c_00), 32'd192);
        chk("duty64_other", 32'(c_other), 32'd0);

        wr(2'd1, 32'd0);
        step(); step();
        c_00 = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (led_pins == 8'h00) c_00++;
        end
        chk("duty0_off", 32'(c_00), 32'd256);

        wr(2'd1, 32'd255);
        step(); step();
        c_ff = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (led_pins == 8'hFF) c_ff++;
        end
        chk("duty255_on", 32'(c_ff), 32'd256);

        // Blink with a two-period half cycle.
        led_value = 8'h01;
        wr(2'd3, 32'd2);
        wr(2'd0, 32'd2);
        step(); step(); step();
        prev = led_pins;
        ntr = 0;
        c_other = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (led_pins != 8'h00 && led_pins != 8'h01) c_other++;
            if (led_pins != prev && ntr < 8) begin
                tr[ntr] = i;
                ntr++;
            end
            prev = led_pins;
        end
        chk("blink_values", 32'(c_other), 32'd0);
        chk("blink_toggles_seen", 32'(ntr >= 3), 32'd1);
        for (int i = 1; i < ntr; i++) begin
            chk($sformatf("blink_interval%0d", i), 32'(tr[i] - tr[i-1]), 32'd512);
        end

        wr(2'd3, 32'd0);
        step(); step(); step();
        c_ff = 0;
        for (int i = 0; i < 600; i++) begin
            step();
            if (led_pins == 8'h01) c_ff++;
        end
        chk("blink_half0_hold", 32'(c_ff), 32'd600);

        // Reset pulse in the blink-on phase.
        wr(2'd3, 32'd2);
        for (int i = 0; i < 10; i++) step();
        chk("blink_on_before_reset", 32'(led_pins), 32'h01);
        led_value = 8'h5A;
        reset_n   = 1'b0;
        step();
        chk("midreset_pins", 32'(led_pins), 32'h00);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            #1;
            chk($sformatf("midreset_rd%0d", a), readdata, 32'h0);
        end
        reset_n = 1'b1;

        // Counters restart from zero: PRESCALE=3 written on the first edge after reset.
        wr(2'd2, 32'd3);
        chk("post_reset_pass", 32'(led_pins), 32'h5A);
        led_value = 8'hFF;
        wr(2'd1, 32'd128);
        wr(2'd0, 32'd1);
        step();
        chk("presc3_first_on", 32'(led_pins), 32'hFF);
        wait_change(8'hFF, 700, n);
        chk("presc3_on_len", 32'(n), 32'd506);
        wait_change(8'h00, 700, n);
        chk("presc3_off_len", 32'(n), 32'd512);

        // PRESCALE rewrite one edge after a tick restarts the prescaler.
        wr(2'd2, 32'd3);
        wait_change(8'hFF, 700, n);
        chk("presc_rewrite_shift", 32'(n), 32'd513);

        // PRESCALE write landing on a tick edge: old value ticks, new value takes over.
        step(); step();
        wr(2'd2, 32'd5);
        address = 2'd2;
        #1;
        chk("presc_tick_write_rd", readdata, 32'd5);
        wait_change(8'h00, 1000, n);
        chk("presc_tick_write_len", 32'(n), 32'd763);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
